// File: rtl/mux16_rr_arbiter_pkg.sv
// mux16_rr_arbiter_pkg: shared state encoding and parameter defaults for the MUX16 arbiter
package mux16_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
  localparam int NREQ_DEF = 16;
  localparam int SEL_W_DEF = 4;
  localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// rr_pick: rotating-priority encoder, first set req at or after ptr (mod NREQ)
module rr_pick
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [2*NREQ-1:0] low, masked;
  // the upper copy of req supplies the wrapped-around candidates below ptr
  assign low = ((2*NREQ)'(1) << ptr) - (2*NREQ)'(1);
  assign masked = {req, req} & ~low;
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 2*NREQ-1; i >= 0; i--)
      if (masked[i]) begin
        found = 1'b1;
        idx = SEL_W'(i % NREQ);
      end
  end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner arbitration and select sequencing for a shared 16:1 mux
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             last,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);
  localparam int HW = MAX_HOLD > 2 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_t state;
  logic [SEL_W-1:0] ptr, inc_sel, pick_ptr, idx;
  logic [HW-1:0] hold_cnt;
  logic found, expire, rel, arb;
  assign inc_sel = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
  assign expire = (MAX_HOLD != 0) && (hold_cnt == HMAX);
  assign rel = (state == ST_OWN) && (last || !req[sel] || expire);
  assign arb = (state == ST_IDLE) || rel;
  // releasing owner moves to lowest priority for the same-cycle re-arbitration
  assign pick_ptr = rel ? inc_sel : ptr;
  rr_pick #(.NREQ(NREQ), .SEL_W(SEL_W)) u_pick (
    .req(req),
    .ptr(pick_ptr),
    .found(found),
    .idx(idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      sel <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= rel && expire && !last && req[sel];
      if (arb) begin
        ptr <= pick_ptr;
        state <= found ? ST_OWN : ST_IDLE;
        busy <= found;
        grant <= found ? NREQ'(1) << idx : '0;
        hold_cnt <= '0;
        if (found) sel <= idx;
      end else if (hold_cnt != HMAX) hold_cnt <= hold_cnt + 1'b1;
    end
endmodule
